// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int FW_DEF    = 3;

  // Scheduler phases: take a command, let the ALU settle, hand back the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps, so every continuously valid requester is
// reached within NREQ grants.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_vld
);

  // Pick the first valid requester after last_grant, wrapping around.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Time-shares one combinational ALU between NREQ requesters. A command is
// registered onto alu_a/b/f, the ALU settles for one cycle, and the result is
// captured and returned tagged with the requester index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds its payload stable while valid is high and not yet
// accepted; ready may depend combinationally on valid, valid never on ready.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FW    = FW_DEF,
  parameter int NREQ  = 2,
  parameter int CNTW  = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*FW-1:0]    req_f,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [FW-1:0]         alu_f,
  input  logic [WIDTH-1:0]      alu_w,
  input  logic                  alu_c,
  input  logic                  alu_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_w,
  output logic                  rsp_c,
  output logic                  rsp_z,
  output logic                  busy,
  output logic [CNTW-1:0]       ops_done,
  output state_t                dbg_state
);

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_vld;
  logic [IDW-1:0]  last_grant;
  logic            accept;
  logic            rsp_fire;
  logic [CNTW-1:0] ops_cnt;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  assign rsp_fire  = rsp_valid && rsp_ready;
  assign ops_done  = ops_cnt;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: one command in flight at a time, EXEC is always one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: only IDLE offers a grant; a grant implies a valid requester.
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    accept    = 1'b0;
    if (state == IDLE) begin
      req_ready = grant;
      busy      = 1'b0;
      accept    = grant_vld;
    end
  end

  // Command capture; alu_* stay put between commands so the ALU is quiet when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_f      <= '0;
      rsp_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      alu_a      <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
      alu_b      <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
      alu_f      <= req_f[int'(grant_idx)*FW +: FW];
      rsp_id     <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // Result capture at the end of EXEC, release and count on response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_w     <= '0;
      rsp_c     <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_valid <= 1'b0;
      ops_cnt   <= '0;
    end else if (state == EXEC) begin
      rsp_w     <= alu_w;
      rsp_c     <= alu_c;
      rsp_z     <= alu_z;
      rsp_valid <= 1'b1;
    end else if (state == RESP && rsp_fire) begin
      rsp_valid <= 1'b0;
      ops_cnt   <= ops_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: ALU stub, transaction-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int WIDTH = 8;
  localparam int FW    = 3;
  localparam int NREQ  = 2;
  localparam int CNTW  = 16;
  localparam int IDW   = 1;
  localparam int EW    = IDW + 2 + WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*FW-1:0]    req_f;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [FW-1:0]         alu_f;
  logic [WIDTH-1:0]      alu_w;
  logic                  alu_c;
  logic                  alu_z;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_w;
  logic                  rsp_c;
  logic                  rsp_z;
  logic                  busy;
  logic [CNTW-1:0]       ops_done;
  state_t                dbg_state;

  alu_rr_scheduler #(.WIDTH(WIDTH), .FW(FW), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_w     (alu_w),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_w     (rsp_w),
    .rsp_c     (rsp_c),
    .rsp_z     (rsp_z),
    .busy      (busy),
    .ops_done  (ops_done),
    .dbg_state (dbg_state)
  );

  // ALU stub: add, carry-out, zero flag; function select ignored.
  always_comb begin
    {alu_c, alu_w} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_z = (alu_w == '0);
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 waiting for a command, 1 result pending, 2 result offered.
  int               m_phase = 0;
  int               m_last  = NREQ - 1;
  logic [WIDTH-1:0] m_a     = '0;
  logic [WIDTH-1:0] m_b     = '0;
  logic [FW-1:0]    m_f     = '0;
  logic [CNTW-1:0]  m_cnt   = '0;
  logic [EW-1:0]    exp_q[$];

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  int             mdl_g;
  logic [WIDTH:0] mdl_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_a     = '0;
      m_b     = '0;
      m_f     = '0;
      m_cnt   = '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          mdl_g = pick(req_valid, m_last);
          if (mdl_g >= 0) begin
            m_a     = req_a[mdl_g*WIDTH +: WIDTH];
            m_b     = req_b[mdl_g*WIDTH +: WIDTH];
            m_f     = req_f[mdl_g*FW +: FW];
            m_last  = mdl_g;
            mdl_sum = {1'b0, m_a} + {1'b0, m_b};
            exp_q.push_back({IDW'(mdl_g), mdl_sum[WIDTH], (mdl_sum[WIDTH-1:0] == '0), mdl_sum[WIDTH-1:0]});
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            m_cnt   = m_cnt + 1'b1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  int              cmp_g;
  logic [NREQ-1:0] cmp_er;
  int              wait_cnt[NREQ];

  always @(negedge clk) begin
    cmp_g  = pick(req_valid, m_last);
    cmp_er = '0;
    if (m_phase == 0 && cmp_g >= 0) cmp_er[cmp_g] = 1'b1;
    chk("req_ready", req_ready, cmp_er);
    chk("busy", busy, m_phase != 0);
    chk("dbg_state_busy", dbg_state != IDLE, m_phase != 0);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_f", alu_f, m_f);
    chk("ops_done", ops_done, m_cnt);
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_data", {rsp_id, rsp_c, rsp_z, rsp_w}, exp_q[0]);
    end
    // A requester held valid must not watch NREQ or more grants go elsewhere.
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || !req_valid[i] || req_ready[i]) wait_cnt[i] = 0;
      else if (req_ready != '0) begin
        wait_cnt[i]++;
        chk("fairness", wait_cnt[i] >= NREQ, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_w;
  logic             r_c;
  logic             r_z;

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  // Returns at the falling edge just before a response handshake.
  task automatic wait_rsp(output logic [IDW-1:0] id, output logic [WIDTH-1:0] w,
                          output logic c, output logic z);
    int k;
    k = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_timeout", k >= 30, 0);
    id = rsp_id;
    w  = rsp_w;
    c  = rsp_c;
    z  = rsp_z;
  endtask

  logic [WIDTH-1:0] t2_w[2] = '{8'h00, 8'h12};
  logic             t2_c[2] = '{1'b1, 1'b0};
  logic             t2_z[2] = '{1'b1, 1'b0};
  logic [NREQ-1:0]  acc;

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_f     = '0;
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n  = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single command from requester 0.
    drive_slot();
    req_a[7:0] = 8'h35;
    req_b[7:0] = 8'hC1;
    req_f[2:0] = 3'd3;
    req_valid  = 2'b01;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 2'b01);
    drive_slot();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_alu_f", alu_f, 3);
    chk("t1_alu_a", alu_a, 8'h35);
    chk("t1_busy", busy, 1);
    chk("t1_no_rsp_yet", rsp_valid, 0);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_w", rsp_w, 8'hF6);
    chk("t1_rsp_c", rsp_c, 0);
    chk("t1_rsp_z", rsp_z, 0);
    @(negedge clk);
    chk("t1_ops_done", ops_done, 1);
    chk("t1_idle", busy, 0);

    // Both requesters valid out of reset: 0 first, then strict alternation.
    drive_slot();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = {8'h11, 8'hFF};
    req_b     = {8'h01, 8'h01};
    req_f     = {3'd2, 3'd1};
    rsp_ready = 1'b1;
    drive_slot();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_rsp(r_id, r_w, r_c, r_z);
      chk("t2_id", r_id, r % 2);
      chk("t2_w", r_w, t2_w[r%2]);
      chk("t2_c", r_c, t2_c[r%2]);
      chk("t2_z", r_z, t2_z[r%2]);
    end

    // Back-pressure: response held stable, no further grant.
    drive_slot();
    rsp_ready = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t3_timeout", k >= 20, 0);
    repeat (5) begin
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_id", rsp_id, 0);
      chk("t3_hold_w", rsp_w, 8'h00);
      chk("t3_hold_c", rsp_c, 1);
      chk("t3_no_grant", req_ready, 0);
      @(negedge clk);
    end
    drive_slot();
    rsp_ready = 1'b1;
    wait_rsp(r_id, r_w, r_c, r_z);
    chk("t3_id", r_id, 0);

    // Reset while a command is executing: dropped, pointer back to 0.
    k = 0;
    @(negedge clk);
    while (!(busy && !rsp_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t4_timeout", k >= 20, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_alu_a", alu_a, 0);
    chk("t4_alu_b", alu_b, 0);
    chk("t4_alu_f", alu_f, 0);
    chk("t4_rsp_w", rsp_w, 0);
    chk("t4_ops_done", ops_done, 0);
    drive_slot();
    rst_n = 1'b1;
    wait_rsp(r_id, r_w, r_c, r_z);
    chk("t4_first_id", r_id, 0);
    chk("t4_first_w", r_w, 8'h00);

    // Counter wrap.
    drive_slot();
    req_valid = 2'b00;
    drive_slot();
    force dut.ops_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release dut.ops_cnt;
    req_a[7:0] = 8'h22;
    req_b[7:0] = 8'h33;
    req_f[2:0] = 3'd5;
    req_valid  = 2'b01;
    drive_slot();
    req_valid = 2'b00;
    wait_rsp(r_id, r_w, r_c, r_z);
    chk("t5_w", r_w, 8'h55);
    @(negedge clk);
    chk("t5_ops_wrap", ops_done, 16'h0000);

    // Idle: nothing moves.
    repeat (10) begin
      @(negedge clk);
      chk("t6_busy", busy, 0);
      chk("t6_req_ready", req_ready, 0);
      chk("t6_alu_a", alu_a, 8'h22);
      chk("t6_alu_b", alu_b, 8'h33);
      chk("t6_alu_f", alu_f, 5);
    end

    // Randomized traffic; payloads only change once accepted or while invalid.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      drive_slot();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i]             = ($urandom_range(0, 2) != 0);
          req_a[i*WIDTH +: WIDTH]  = WIDTH'($urandom_range(0, 255));
          req_b[i*WIDTH +: WIDTH]  = WIDTH'($urandom_range(0, 255));
          req_f[i*FW +: FW]        = FW'($urandom_range(0, 7));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain.
    @(negedge clk);
    drive_slot();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_idle", busy, 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
